// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Main control FSM for the multicycle RV32I core. Sequences the shared ALU,
//   register file, instruction register and unified memory through
//   Fetch / Decode / Execute / Memory / Writeback steps for lw, sw, R-type,
//   I-type ALU, beq and jal. Any other opcode is flagged illegal in Decode and
//   the instruction is dropped (straight back to Fetch).
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   op[6:0]    in   opcode from the instruction register
//   zero       in   ALU Zero flag (only consulted in the BEQ state)
//   mem_ready  in   memory completed the current access this cycle
//   PCWrite    out  PC enable = PCUpdate | (Branch & zero)
//   AdrSrc     out  memory address select: 0 = PC, 1 = Result
//   MemWrite   out  memory write strobe
//   IRWrite    out  instruction register / OldPC enable
//   ResultSrc  out  00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUSrcA    out  00 = PC, 01 = OldPC, 10 = A
//   ALUSrcB    out  00 = WriteData, 01 = ImmExt, 10 = constant 4
//   ALUOp      out  00 = add, 01 = sub, 10 = use funct fields
//   RegWrite   out  register file write enable
//   illegal    out  one-cycle pulse when Decode sees an unsupported opcode
//   state[3:0] out  current state encoding (debug)
//
// The Moore part of the decode is registered: it is computed from the next
// state and loaded on the same edge as the state register, so the outputs
// are flop-driven. Only the mem_ready gating in Fetch, the zero term of the
// branch, the opcode check in Decode and the reset forcing are combinational.
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S0_FETCH    = 4'd0,
    S1_DECODE   = 4'd1,
    S2_MEMADR   = 4'd2,
    S3_MEMREAD  = 4'd3,
    S4_MEMWB    = 4'd4,
    S5_MEMWRITE = 4'd5,
    S6_EXECR    = 4'd6,
    S7_ALUWB    = 4'd7,
    S8_EXECI    = 4'd8,
    S9_JAL      = 4'd9,
    S10_BEQ     = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  // Moore control word; fetch marks S0 where IRWrite/PCUpdate follow mem_ready.
  typedef struct packed {
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       reg_write;
    logic       fetch;
    logic       pc_update;
    logic       branch;
  } ctrl_t;

  state_t state_r;
  state_t next_state_s;
  ctrl_t  ctrl_r;

  // Control word for a given state; unused encodings decode to all zeros.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S0_FETCH: begin
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.fetch      = 1'b1;
      end
      S1_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S2_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S3_MEMREAD: begin
        c.adr_src = 1'b1;
      end
      S4_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S5_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S6_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S7_ALUWB: begin
        c.reg_write = 1'b1;
      end
      S8_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S9_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      S10_BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // True for the opcodes this controller knows how to sequence.
  function automatic logic op_supported(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) ||
           (o == OP_I) || (o == OP_JAL) || (o == OP_BEQ);
  endfunction

  // Next-state logic, including the memory-ready stalls.
  always_comb begin
    next_state_s = S0_FETCH;
    case (state_r)
      S0_FETCH:    next_state_s = mem_ready ? S1_DECODE : S0_FETCH;
      S1_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state_s = S2_MEMADR;
          OP_R:         next_state_s = S6_EXECR;
          OP_I:         next_state_s = S8_EXECI;
          OP_JAL:       next_state_s = S9_JAL;
          OP_BEQ:       next_state_s = S10_BEQ;
          default:      next_state_s = S0_FETCH;
        endcase
      end
      S2_MEMADR:   next_state_s = op[5] ? S5_MEMWRITE : S3_MEMREAD;
      S3_MEMREAD:  next_state_s = mem_ready ? S4_MEMWB : S3_MEMREAD;
      S4_MEMWB:    next_state_s = S0_FETCH;
      S5_MEMWRITE: next_state_s = mem_ready ? S0_FETCH : S5_MEMWRITE;
      S6_EXECR:    next_state_s = S7_ALUWB;
      S7_ALUWB:    next_state_s = S0_FETCH;
      S8_EXECI:    next_state_s = S7_ALUWB;
      S9_JAL:      next_state_s = S7_ALUWB;
      S10_BEQ:     next_state_s = S0_FETCH;
      default:     next_state_s = S0_FETCH;
    endcase
  end

  // State register with the registered Moore control word alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S0_FETCH;
      ctrl_r  <= decode_ctrl(S0_FETCH);
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= decode_ctrl(next_state_s);
    end
  end

  // Output assembly: reset forces every enable low, selects keep S0 values.
  always_comb begin
    AdrSrc    = ctrl_r.adr_src;
    ResultSrc = ctrl_r.result_src;
    ALUSrcA   = ctrl_r.alu_src_a;
    ALUSrcB   = ctrl_r.alu_src_b;
    ALUOp     = ctrl_r.alu_op;
    state     = state_r;
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end else begin
      IRWrite  = ctrl_r.fetch & mem_ready;
      PCWrite  = (ctrl_r.fetch & mem_ready) | ctrl_r.pc_update |
                 (ctrl_r.branch & zero);
      MemWrite = ctrl_r.mem_write;
      RegWrite = ctrl_r.reg_write;
      illegal  = (state_r == S1_DECODE) & ~op_supported(op);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Directed self-checking bench for multicycle_controller. Inputs change 1
//   time unit after each rising edge; outputs are checked 1 unit later.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       RegWrite;
  logic       illegal;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .RegWrite  (RegWrite),
    .illegal   (illegal),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // All five enables low.
  task automatic chk_enables_low(input string tag);
    chk({tag, ".PCWrite"},  8'(PCWrite),  8'd0);
    chk({tag, ".IRWrite"},  8'(IRWrite),  8'd0);
    chk({tag, ".MemWrite"}, 8'(MemWrite), 8'd0);
    chk({tag, ".RegWrite"}, 8'(RegWrite), 8'd0);
    chk({tag, ".illegal"},  8'(illegal),  8'd0);
  endtask

  initial begin
    reset = 1'b1; op = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    next_cycle(); next_cycle(); #1;
    // Reset: S0, enables low even with mem_ready=1, S0 selects shown.
    chk("rst.state", 8'(state), 8'd0);
    chk_enables_low("rst");
    chk("rst.ResultSrc", 8'(ResultSrc), 8'd2);
    chk("rst.ALUSrcB",   8'(ALUSrcB),   8'd2);
    chk("rst.AdrSrc",    8'(AdrSrc),    8'd0);
    next_cycle();
    reset = 1'b0;

    // ---------------- R-type: S0 S1 S6 S7 S0 ----------------
    op = 7'b0110011; mem_ready = 1'b1; #1;
    chk("r.s0.state",   8'(state),   8'd0);
    chk("r.s0.IRWrite", 8'(IRWrite), 8'd1);
    chk("r.s0.PCWrite", 8'(PCWrite), 8'd1);
    next_cycle(); #1;
    chk("r.s1.state",    8'(state),    8'd1);
    chk("r.s1.ALUSrcA",  8'(ALUSrcA),  8'd1);
    chk("r.s1.ALUSrcB",  8'(ALUSrcB),  8'd1);
    chk("r.s1.RegWrite", 8'(RegWrite), 8'd0);
    chk("r.s1.illegal",  8'(illegal),  8'd0);
    chk("r.s1.IRWrite",  8'(IRWrite),  8'd0);
    next_cycle(); #1;
    chk("r.s6.state",    8'(state),    8'd6);
    chk("r.s6.ALUOp",    8'(ALUOp),    8'd2);
    chk("r.s6.ALUSrcA",  8'(ALUSrcA),  8'd2);
    chk("r.s6.RegWrite", 8'(RegWrite), 8'd0);
    next_cycle(); #1;
    chk("r.s7.state",     8'(state),     8'd7);
    chk("r.s7.RegWrite",  8'(RegWrite),  8'd1);
    chk("r.s7.ResultSrc", 8'(ResultSrc), 8'd0);
    next_cycle(); #1;
    chk("r.end.state",    8'(state),    8'd0);
    chk("r.end.RegWrite", 8'(RegWrite), 8'd0);

    // Fetch stall: mem_ready=0 holds S0 with IRWrite/PCWrite low.
    mem_ready = 1'b0; op = 7'b0000011; #1;
    chk("f.stall.IRWrite", 8'(IRWrite), 8'd0);
    chk("f.stall.PCWrite", 8'(PCWrite), 8'd0);
    next_cycle(); #1;
    chk("f.stall.state", 8'(state), 8'd0);

    // ---------------- lw with 2 stall cycles in S3 ----------------
    mem_ready = 1'b1; #1;
    chk("lw.s0.state", 8'(state), 8'd0);
    next_cycle(); #1;
    chk("lw.s1.state", 8'(state), 8'd1);
    next_cycle(); #1;
    chk("lw.s2.state",   8'(state),   8'd2);
    chk("lw.s2.ALUSrcA", 8'(ALUSrcA), 8'd2);
    chk("lw.s2.ALUSrcB", 8'(ALUSrcB), 8'd1);
    next_cycle(); mem_ready = 1'b0; #1;
    chk("lw.s3a.state",  8'(state),  8'd3);
    chk("lw.s3a.AdrSrc", 8'(AdrSrc), 8'd1);
    next_cycle(); #1;
    chk("lw.s3b.state", 8'(state), 8'd3);
    next_cycle(); mem_ready = 1'b1; #1;
    chk("lw.s3c.state", 8'(state), 8'd3);
    chk("lw.s3c.RegWrite", 8'(RegWrite), 8'd0);
    next_cycle(); #1;
    chk("lw.s4.state",     8'(state),     8'd4);
    chk("lw.s4.RegWrite",  8'(RegWrite),  8'd1);
    chk("lw.s4.ResultSrc", 8'(ResultSrc), 8'd1);
    next_cycle(); #1;
    chk("lw.end.state", 8'(state), 8'd0);

    // ---------------- sw with 1 stall cycle in S5 ----------------
    op = 7'b0100011; #1;
    next_cycle(); #1;
    chk("sw.s1.state", 8'(state), 8'd1);
    next_cycle(); #1;
    chk("sw.s2.state", 8'(state), 8'd2);
    next_cycle(); mem_ready = 1'b0; #1;
    chk("sw.s5a.state",    8'(state),    8'd5);
    chk("sw.s5a.MemWrite", 8'(MemWrite), 8'd1);
    chk("sw.s5a.AdrSrc",   8'(AdrSrc),   8'd1);
    next_cycle(); mem_ready = 1'b1; #1;
    chk("sw.s5b.state",    8'(state),    8'd5);
    chk("sw.s5b.MemWrite", 8'(MemWrite), 8'd1);
    chk("sw.s5b.AdrSrc",   8'(AdrSrc),   8'd1);
    next_cycle(); #1;
    chk("sw.end.state",    8'(state),    8'd0);
    chk("sw.end.MemWrite", 8'(MemWrite), 8'd0);

    // ---------------- beq taken, then zero toggled in S10 ----------------
    op = 7'b1100011; #1;
    next_cycle(); zero = 1'b1; #1;
    chk("beq.s1.state",   8'(state),   8'd1);
    chk("beq.s1.PCWrite", 8'(PCWrite), 8'd0);   // zero ignored outside S10
    next_cycle(); #1;
    chk("beq1.s10.state",   8'(state),   8'd10);
    chk("beq1.s10.PCWrite", 8'(PCWrite), 8'd1);
    chk("beq1.s10.ALUOp",   8'(ALUOp),   8'd1);
    zero = 1'b0; #1;
    chk("beq1.s10.follow0", 8'(PCWrite), 8'd0);
    next_cycle(); #1;
    chk("beq1.end.state", 8'(state), 8'd0);

    // beq not taken
    next_cycle(); #1;
    next_cycle(); #1;
    chk("beq0.s10.state",   8'(state),   8'd10);
    chk("beq0.s10.PCWrite", 8'(PCWrite), 8'd0);
    chk("beq0.s10.ALUOp",   8'(ALUOp),   8'd1);
    next_cycle(); #1;
    chk("beq0.end.state", 8'(state), 8'd0);

    // ---------------- jal: S0 S1 S9 S7 S0 ----------------
    op = 7'b1101111; #1;
    next_cycle(); #1;
    next_cycle(); #1;
    chk("jal.s9.state",    8'(state),    8'd9);
    chk("jal.s9.PCWrite",  8'(PCWrite),  8'd1);
    chk("jal.s9.ALUSrcA",  8'(ALUSrcA),  8'd1);
    chk("jal.s9.ALUSrcB",  8'(ALUSrcB),  8'd2);
    chk("jal.s9.RegWrite", 8'(RegWrite), 8'd0);
    next_cycle(); #1;
    chk("jal.s7.state",    8'(state),    8'd7);
    chk("jal.s7.RegWrite", 8'(RegWrite), 8'd1);
    next_cycle(); #1;
    chk("jal.end.state", 8'(state), 8'd0);

    // ---------------- illegal opcode: S0 S1 S0 ----------------
    op = 7'b0000000; #1;
    chk("ill.s0.illegal", 8'(illegal), 8'd0);
    next_cycle(); #1;
    chk("ill.s1.state",   8'(state),   8'd1);
    chk("ill.s1.illegal", 8'(illegal), 8'd1);
    next_cycle(); #1;
    chk("ill.end.state",   8'(state),   8'd0);
    chk("ill.end.illegal", 8'(illegal), 8'd0);

    // ---------------- reset asserted while in S3 ----------------
    op = 7'b0000011; #1;
    next_cycle(); #1;
    next_cycle(); #1;
    next_cycle(); mem_ready = 1'b0; #1;
    chk("rs.pre.state", 8'(state), 8'd3);
    reset = 1'b1; mem_ready = 1'b1; #1;
    chk("rs.async.state", 8'(state), 8'd0);
    chk_enables_low("rs.async");
    next_cycle(); #1;
    chk("rs.hold.state", 8'(state), 8'd0);
    chk_enables_low("rs.hold");
    reset = 1'b0; #1;
    chk("rs.rel.state",   8'(state),   8'd0);
    chk("rs.rel.IRWrite", 8'(IRWrite), 8'd1);
    next_cycle(); #1;
    chk("rs.fetch.state", 8'(state), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I core. It sequences the shared ALU, register file, instruction register and unified memory across Fetch/Decode/Execute/Memory/Writeback steps. It drives ALUOp into the ALU decoder, selects the ALU operands, and stalls on a memory ready handshake. It covers lw, sw, R-type, I-type ALU, beq and jal; any other opcode is flagged illegal and skipped.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- op  in  7  instruction opcode, taken from the instruction register
- zero  in  1  ALU Zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register (and OldPC) enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A operand select: 00 = PC, 01 = OldPC, 10 = A
- ALUSrcB  out  2  ALU B operand select: 00 = WriteData, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = use funct fields
- RegWrite  out  1  register file write enable
- illegal  out  1  one-cycle pulse when Decode sees an unsupported opcode
- state  out  4  current state encoding, for debug

## Operation
- State encodings are S0 to S10, equal to the state number.
- All outputs are Moore-decoded from the state, except the mem_ready gating and the branch term in PCWrite.
- Any output not listed for a state is 0.
- PCWrite = PCUpdate | (Branch & zero). PCUpdate and Branch are internal signals.
- S0 Fetch:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCUpdate = mem_ready.
  - Stays in S0 while mem_ready=0; goes to S1 when mem_ready=1.
- S1 Decode: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> S2
  - 0110011 -> S6
  - 0010011 -> S8
  - 1101111 -> S9
  - 1100011 -> S10
  - any other op -> S0, with illegal=1
- S2 MemAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to S3 if op[5]=0, otherwise to S5.
- S3 MemRead: ResultSrc=00, AdrSrc=1. Holds until mem_ready=1, then goes to S4.
- S4 MemWB: ResultSrc=01, RegWrite=1. Goes to S0.
- S5 MemWrite: ResultSrc=00, AdrSrc=1, MemWrite=1. Holds with MemWrite asserted until mem_ready=1, then goes to S0.
- S6 ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to S7.
- S7 ALUWB: ResultSrc=00, RegWrite=1. Goes to S0.
- S8 ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to S7.
- S9 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Goes to S7.
- S10 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Goes to S0.
- Unused encodings 11 to 15 go to S0 on the next edge, with all enables 0.

## Timing
- Reset:
  - The state register clears to S0 immediately on assertion of reset (asynchronous).
  - While reset=1: PCWrite, IRWrite, MemWrite, RegWrite and illegal are forced to 0; the mux selects show their S0 values.
- Reset asserted mid-instruction aborts it; the first Fetch follows the first rising edge after release.
- Instruction cycle counts, with mem_ready held at 1:
  - lw: 5
  - sw: 4
  - R-type and I-type: 4
  - jal: 4
  - beq: 3
  - illegal opcode: 2
- Each cycle of mem_ready=0 in S0, S3 or S5 adds one cycle.
- MemWrite and AdrSrc stay stable throughout a stall in S5.
- In S10, PCWrite follows zero combinationally in the same cycle.
- zero is ignored in every other state.
- illegal is high only during the S1 cycle that decodes the unsupported opcode.

## Test plan
- Reset, then op=0110011 with mem_ready=1:
  - states are S0, S1, S6, S7, S0
  - RegWrite=1 only in S7
  - ALUOp=10 in S6
- lw (op=0000011) with mem_ready low for 2 cycles in S3:
  - states are S0, S1, S2, S3, S3, S3, S4, S0
  - RegWrite=1 with ResultSrc=01 in S4
- sw (op=0100011) with mem_ready=0 for 1 cycle in S5:
  - MemWrite=1 for 2 consecutive cycles with AdrSrc=1
  - returns to S0
- beq (op=1100011):
  - with zero=1 in S10: PCWrite=1
  - with zero=0 in S10: PCWrite=0
  - in both cases ALUOp=01 in S10 and the next state is S0
- jal (op=1101111):
  - PCWrite=1 in S9
  - next states are S7 (RegWrite=1), then S0
- Illegal and reset cases:
  - op=0000000: illegal pulses for one cycle in S1, then the state returns to S0
  - reset asserted while in S3: state=S0 immediately and all enables are 0 until reset is released
